// File: rtl/regfile_sequencer.sv
// Command sequencer for the 2-read/1-masked-write register file.
// Hides the file's registered read latency behind a valid/ready response.
module regfile_sequencer #(
    parameter int N = 32,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [M-1:0] cmd_a,
    input  logic [M-1:0] cmd_b,
    input  logic [N-1:0] cmd_data,
    input  logic [N-1:0] cmd_mask,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_op,
    output logic [N-1:0] rsp_data1,
    output logic [N-1:0] rsp_data2,
    output logic         rsp_carry,
    output logic [M-1:0] rf_r1,
    output logic [M-1:0] rf_r2,
    output logic [M-1:0] rf_w1,
    output logic [N-1:0] rf_mask,
    output logic [N-1:0] rf_w,
    input  logic [N-1:0] rf_v1,
    input  logic [N-1:0] rf_v2
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INCR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WB,
        RESP
    } state_t;

    state_t       state_q, state_d;
    logic         cmd_ready_q, cmd_ready_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] data_q, data_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [1:0]   rsp_op_q, rsp_op_d;
    logic [N-1:0] rsp_data1_q, rsp_data1_d;
    logic [N-1:0] rsp_data2_q, rsp_data2_d;
    logic         rsp_carry_q, rsp_carry_d;
    logic [M-1:0] rf_r1_q, rf_r1_d;
    logic [M-1:0] rf_r2_q, rf_r2_d;
    logic [M-1:0] rf_w1_q, rf_w1_d;
    logic [N-1:0] rf_mask_q, rf_mask_d;
    logic [N-1:0] rf_w_q, rf_w_d;
    logic [N:0]   sum;

    assign sum = {1'b0, rf_v1} + {1'b0, data_q};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rsp_carry_d = rsp_carry_q;
        rf_r1_d     = rf_r1_q;
        rf_r2_d     = rf_r2_q;
        rf_w1_d     = rf_w1_q;
        rf_w_d      = rf_w_q;
        // the file writes every cycle, so the mask must drop back to zero
        rf_mask_d   = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_READ: begin
                            rf_r1_d = cmd_a;
                            rf_r2_d = cmd_b;
                            state_d = RD1;
                        end
                        OP_WRITE: begin
                            rf_w1_d   = cmd_a;
                            rf_w_d    = cmd_data;
                            rf_mask_d = cmd_mask;
                            state_d   = WB;
                        end
                        OP_INCR: begin
                            rf_r1_d = cmd_a;
                            state_d = RD1;
                        end
                        default: ;
                    endcase
                end
            end
            RD1: state_d = RD2;
            RD2: begin
                rsp_op_d    = op_q;
                rsp_data1_d = rf_v1;
                if (op_q == OP_READ) begin
                    rsp_data2_d = rf_v2;
                    rsp_carry_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    rsp_data2_d = sum[N-1:0];
                    rsp_carry_d = sum[N];
                    rf_w1_d     = rf_r1_q;
                    rf_w_d      = sum[N-1:0];
                    rf_mask_d   = '1;
                    state_d     = WB;
                end
            end
            WB: begin
                rsp_op_d    = op_q;
                rsp_valid_d = 1'b1;
                if (op_q == OP_WRITE) begin
                    rsp_data1_d = '0;
                    rsp_data2_d = '0;
                    rsp_carry_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            op_q        <= OP_NOP;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_carry_q <= 1'b0;
            rf_r1_q     <= '0;
            rf_r2_q     <= '0;
            rf_w1_q     <= '0;
            rf_mask_q   <= '0;
            rf_w_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_carry_q <= rsp_carry_d;
            rf_r1_q     <= rf_r1_d;
            rf_r2_q     <= rf_r2_d;
            rf_w1_q     <= rf_w1_d;
            rf_mask_q   <= rf_mask_d;
            rf_w_q      <= rf_w_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign rsp_carry = rsp_carry_q;
    assign rf_r1     = rf_r1_q;
    assign rf_r2     = rf_r2_q;
    assign rf_w1     = rf_w1_q;
    assign rf_mask   = rf_mask_q;
    assign rf_w      = rf_w_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register file model, directed table,
// reset/NOP sequences and random commands against a register-array model.
module tb_regfile_sequencer;

    logic        clk = 0;
    logic        rst = 1;
    logic        clr = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [1:0]  cmd_a = 0;
    logic [1:0]  cmd_b = 0;
    logic [31:0] cmd_data = 0;
    logic [31:0] cmd_mask = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_data1, rsp_data2;
    logic        rsp_carry;
    logic [1:0]  rf_r1, rf_r2, rf_w1;
    logic [31:0] rf_mask, rf_w;
    logic [31:0] rf_v1, rf_v2;

    logic [31:0] regs [4];
    logic [31:0] gold [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.N(32), .M(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rsp_carry(rsp_carry),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_w1(rf_w1),
        .rf_mask(rf_mask), .rf_w(rf_w),
        .rf_v1(rf_v1), .rf_v2(rf_v2)
    );

    // register file: registered reads, masked write every cycle
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            rf_v1 <= '0;
            rf_v2 <= '0;
        end else begin
            rf_v1 <= regs[rf_r1];
            rf_v2 <= regs[rf_r2];
            regs[rf_w1] <= (regs[rf_w1] & ~rf_mask) | (rf_w & rf_mask);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] data;
        logic [31:0] mask;
        int          hold;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ec;
    } vec_t;

    // Caller sits at a negedge; returns at a negedge with the response taken.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [31:0] data,
                           input logic [31:0] mask, input int hold,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic ec);
        int n;
        int lat;
        int mcount;
        int exp_lat;
        logic [31:0] s1, s2;
        logic [1:0] sop;
        logic sc;
        logic [32:0] sum;
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_data = data; cmd_mask = mask;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        cmd_op = 2'($urandom); cmd_a = 2'($urandom); cmd_b = 2'($urandom);
        cmd_data = $urandom; cmd_mask = $urandom;
        if (op == 2'b00) begin
            for (int i = 0; i < 3; i++) begin
                chk("nop_no_rsp", 32'(rsp_valid), 32'd0);
                chk("nop_ready", 32'(cmd_ready), 32'd1);
                chk("nop_mask", rf_mask, 32'd0);
                @(negedge clk);
            end
            return;
        end
        mcount = (rf_mask != 0) ? 1 : 0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rf_mask != 0) mcount++;
        end
        exp_lat = (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 3;
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!rsp_valid) return;
        chk("rsp_op", 32'(rsp_op), 32'(op));
        chk("rsp_data1", rsp_data1, e1);
        chk("rsp_data2", rsp_data2, e2);
        chk("rsp_carry", 32'(rsp_carry), 32'(ec));
        s1 = rsp_data1; s2 = rsp_data2; sop = rsp_op; sc = rsp_carry;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rf_mask != 0) mcount++;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_ready", 32'(cmd_ready), 32'd0);
            chk("hold_d1", rsp_data1, s1);
            chk("hold_d2", rsp_data2, s2);
            chk("hold_op_c", {29'd0, sop, sc}, {29'd0, rsp_op, rsp_carry});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        if (rf_mask != 0) mcount++;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
        chk("mask_cycles", 32'(mcount), (op == 2'b01) ? 32'd0 : 32'd1);
        if (op == 2'b10) gold[a] = (gold[a] & ~mask) | (data & mask);
        if (op == 2'b11) begin
            sum = {1'b0, gold[a]} + {1'b0, data};
            gold[a] = sum[31:0];
        end
    endtask

    vec_t vecs [13];

    initial begin
        logic [1:0] op, a, b;
        logic [31:0] d, m, e1, e2;
        logic ec;
        logic [32:0] s;

        vecs[0]  = '{2'b10, 2, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 0, 0};
        vecs[1]  = '{2'b01, 2, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vecs[2]  = '{2'b10, 1, 0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0, 0};
        vecs[3]  = '{2'b10, 1, 0, 32'hAAAAAAAA, 32'h0000FFFF, 0, 0, 0, 0};
        vecs[4]  = '{2'b01, 1, 1, 0, 0, 0, 32'h1234AAAA, 32'h1234AAAA, 0};
        vecs[5]  = '{2'b10, 3, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 0, 0};
        vecs[6]  = '{2'b11, 3, 0, 32'd3, 0, 0, 32'hFFFFFFFE, 32'd1, 1};
        vecs[7]  = '{2'b01, 3, 3, 0, 0, 0, 32'd1, 32'd1, 0};
        vecs[8]  = '{2'b01, 2, 1, 0, 0, 5, 32'hDEADBEEF, 32'h1234AAAA, 0};
        vecs[9]  = '{2'b10, 0, 0, 32'd5, 32'hFFFFFFFF, 0, 0, 0, 0};
        vecs[10] = '{2'b01, 0, 0, 0, 0, 0, 32'd5, 32'd5, 0};
        vecs[11] = '{2'b11, 0, 0, 32'd0, 0, 0, 32'd5, 32'd5, 0};
        vecs[12] = '{2'b10, 2, 0, 32'd7, 32'hFFFFFFFF, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) gold[i] = '0;

        repeat (2) @(negedge clk);
        clr = 0;
        @(negedge clk);
        rst = 0;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_d1", rsp_data1, 32'd0);
        chk("rst_d2", rsp_data2, 32'd0);
        chk("rst_mask", rf_mask, 32'd0);
        chk("rst_w", rf_w, 32'd0);
        chk("rst_addr", {24'd0, rsp_op, rf_r1, rf_r2, rf_w1}, 32'd0);
        chk("rst_carry", 32'(rsp_carry), 32'd0);

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data,
                    vecs[i].mask, vecs[i].hold, vecs[i].e1, vecs[i].e2,
                    vecs[i].ec);

        // reset while an INCR of reg 2 sits in RD2
        cmd_valid = 1; cmd_op = 2'b11; cmd_a = 2; cmd_data = 32'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_mask", rf_mask, 32'd0);
        chk("abort_d1", rsp_data1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_mask", rf_mask, 32'd0);
            chk("post_abort_valid", 32'(rsp_valid), 32'd0);
        end
        run_cmd(2'b01, 2, 2, 0, 0, 0, 32'd7, 32'd7, 0);
        run_cmd(2'b00, 1, 1, 32'd9, 32'hFFFFFFFF, 0, 0, 0, 0);
        run_cmd(2'b01, 1, 2, 0, 0, 0, 32'h1234AAAA, 32'd7, 0);

        for (int k = 0; k < 60; k++) begin
            op = 2'($urandom_range(0, 3));
            a = 2'($urandom); b = 2'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4))
                                            : $urandom;
            m = $urandom;
            e1 = 0; e2 = 0; ec = 0;
            if (op == 2'b01) begin
                e1 = gold[a]; e2 = gold[b];
            end else if (op == 2'b11) begin
                s = {1'b0, gold[a]} + {1'b0, d};
                e1 = gold[a]; e2 = s[31:0]; ec = s[32];
            end
            run_cmd(op, a, b, d, m, $urandom_range(0, 3), e1, e2, ec);
        end
        for (int i = 0; i < 4; i++)
            run_cmd(2'b01, 2'(i), 2'(3 - i), 0, 0, 0, gold[i], gold[3 - i], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-side initiator for the 2-read/1-masked-write register file. Converts host commands (READ pair, masked WRITE, INCR read-modify-write) into correctly timed register-file port activity.
- Absorbs the file's one-cycle registered read latency and its every-cycle write behaviour.
- Returns results on a valid/ready response channel.
- Sits between the CPU control/debug logic and the register file.

Parameters:
N, 32, register data width (must match register file N)
M, 2, register address width (2^M registers)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept command this cycle
cmd_op  input  2  00 NOP, 01 READ, 10 WRITE, 11 INCR
cmd_a  input  M  primary register id (read port 1 / write target)
cmd_b  input  M  second read register id (READ only)
cmd_data  input  N  write value (WRITE) or increment (INCR)
cmd_mask  input  N  write mask (WRITE only)
rsp_valid  output  1  response available
rsp_ready  input  1  host accepts response
rsp_op  output  2  op of completed command
rsp_data1  output  N  READ: regs[a]; INCR: old regs[a]; WRITE: 0
rsp_data2  output  N  READ: regs[b]; INCR: new value; WRITE: 0
rsp_carry  output  1  INCR carry-out of the add; 0 otherwise
rf_r1  output  M  to register file r1
rf_r2  output  M  to register file r2
rf_w1  output  M  to register file w1
rf_mask  output  N  to register file mask
rf_w  output  N  to register file w
rf_v1  input  N  from register file v1
rf_v2  input  N  from register file v2

Behaviour:
- All outputs registered.
- States: IDLE, RD1, RD2, WB, RESP.
- Reset (rst high at a posedge), values after the edge:
  - state=IDLE, cmd_ready=1, rsp_valid=0.
  - rsp_op, rsp_data1, rsp_data2, rsp_carry, rf_r1, rf_r2, rf_w1, rf_w and rf_mask all 0.
- rf_mask is nonzero for exactly one cycle per WRITE/INCR, and 0 in every other cycle including reset.
- cmd_ready=1 only in IDLE. A command is accepted on an edge with cmd_valid&cmd_ready; call that edge E0.
- NOP: accepted, no register-file activity, no response, stays IDLE.
- READ:
  - E0: rf_r1=a, rf_r2=b → RD1.
  - E1: register file samples → RD2.
  - E2: capture rf_v1/rf_v2 into rsp_data1/2, rsp_valid=1 → RESP.
  - Latency accept→rsp_valid is 2 cycles.
- WRITE:
  - E0: rf_w1=a, rf_w=data, rf_mask=mask → WB.
  - E1: register file commits; rf_mask=0, rsp_valid=1, data outputs 0 → RESP.
- INCR:
  - E0: rf_r1=a → RD1.
  - E1: → RD2.
  - E2: rf_w1=a, rf_w=(rf_v1+data) mod 2^N, rf_mask=all ones; latch old=rf_v1, new, carry → WB.
  - E3: rf_mask=0, rsp_valid=1 → RESP.
- RESP:
  - Response fields held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid=0, state=IDLE, cmd_ready=1 the same edge.
  - The next command is accepted no earlier than the following edge.
- Hazards:
  - A write committed at edge Ek is visible to a read sampled at Ek+1 or later.
  - Because of RESP, any command accepted after a WRITE/INCR samples the register file at least 2 edges after commit. No forwarding is required.
  - READ/INCR sampling takes place at E1 from rf_r1/rf_r2 as driven at E0.
- Register ids: cmd_a==cmd_b for READ returns the same value on both data outputs.
- INCR arithmetic:
  - N-bit wrap; rsp_carry = bit N of the (N+1)-bit sum.
  - data=0 rewrites the same value and returns carry 0.
- Inputs are sampled only at acceptance; cmd_* changes afterwards have no effect.
- Reset mid-operation:
  - Aborts the command, returns to IDLE and drops any pending response.
  - A write whose rf_mask was already driven before the reset edge is committed by the register file at that edge.
  - The sequencer guarantees no further writes after it.

Test Plan:
1. Reset, then WRITE a=2 data=0xDEADBEEF mask=0xFFFFFFFF; READ a=2 b=0 → rsp_data1=0xDEADBEEF, rsp_data2=0; rsp_valid exactly 2 cycles after READ acceptance; rf_mask high for one cycle only.
2. WRITE a=1 data=0x12345678 mask=0xFFFFFFFF, then WRITE a=1 data=0xAAAAAAAA mask=0x0000FFFF, READ a=1 b=1 → both data outputs 0x1234AAAA.
3. WRITE a=3 data=0xFFFFFFFE full mask; INCR a=3 data=3 → rsp_data1=0xFFFFFFFE, rsp_data2=0x00000001, rsp_carry=1; subsequent READ a=3 → 0x00000001.
4. Back-pressure: READ with rsp_ready low for 5 cycles → rsp fields stable, cmd_ready=0 throughout, no rf_mask activity; after rsp_ready=1, cmd_ready=1 the next cycle.
5. Back-to-back WRITE a=0 data=5 then immediate READ a=0 → returns 5, proving the write has committed before the next read samples.
6. Assert rst during RD2 of an INCR on a=2 (value 7) → no response; rf_mask stays 0; READ a=2 afterwards returns 7. NOP accepted in IDLE → no response, cmd_ready remains 1.
